cover_toggle_collector: RTL and testbench

//  Hardware sink for toggle-coverage events, for FPGA/emulation builds where DPI is unavailable.

---
 rtl/cover_pkg.sv | 22 ++
 rtl/cover_dump_streamer.sv | 82 ++++++++
 rtl/cover_toggle_collector.sv | 114 +++++++++++
 tb/tb_cover_toggle_collector.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cover_pkg.sv
// Shared constants and types for the toggle-coverage collector.
// Bitmap geometry, counter widths and the collector FSM states.
package cover_pkg;

  localparam int COVER_TOTAL = 10906;
  localparam int LANES       = 7;
  localparam int WORD_W      = 32;
  localparam int NUM_WORDS   = (COVER_TOTAL + WORD_W - 1) / WORD_W;
  localparam int IDX_W       = $clog2(COVER_TOTAL);
  localparam int AW          = $clog2(NUM_WORDS);
  localparam int BIT_W       = $clog2(WORD_W);
  localparam int CNT_W       = IDX_W + 1;

  typedef logic [WORD_W-1:0] cover_word_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DUMP
  } coll_state_e;

endpackage

// File: rtl/cover_dump_streamer.sv
// Collector FSM and bitmap readout port: IDLE/CLEAR/DUMP,
// valid/ready word stream, rd_addr/rd_last and the registered word.
module cover_dump_streamer
  import cover_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_clr_req,
  input  logic          i_dump_req,
  input  logic          i_rd_ready,
  input  cover_word_t   i_word,
  output logic [AW-1:0] o_sel,
  output logic          o_clear,
  output logic          o_dump_busy,
  output logic          o_rd_valid,
  output logic          o_rd_last,
  output cover_word_t   o_rd_data,
  output logic [AW-1:0] o_rd_addr
);

  coll_state_e   r_state;
  coll_state_e   w_state_nx;
  logic [AW-1:0] r_addr;
  cover_word_t   r_data;
  logic          w_last;
  logic          w_hs;
  logic          w_load;

  assign w_last = (r_addr == AW'(NUM_WORDS - 1));
  assign w_hs   = (r_state == DUMP) && i_rd_ready;

  // next state and which word to latch (first word, or the one after a handshake)
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    o_sel      = r_addr + AW'(1);
    unique case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nx = CLEAR;
        end else if (i_dump_req) begin
          w_state_nx = DUMP;
          w_load     = 1'b1;
          o_sel      = '0;
        end
      end
      CLEAR: w_state_nx = IDLE;
      DUMP: begin
        if (w_hs) begin
          if (w_last) w_state_nx = IDLE;
          else        w_load     = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // state, address and word register; address parks at 0 after the last word
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_data <= i_word;
        r_addr <= o_sel;
      end else if (w_hs) begin
        r_addr <= '0;
      end
    end
  end

  assign o_clear     = (r_state == CLEAR);
  assign o_dump_busy = (r_state != IDLE);
  assign o_rd_valid  = (r_state == DUMP);
  assign o_rd_last   = (r_state == DUMP) && w_last;
  assign o_rd_data   = r_data;
  assign o_rd_addr   = r_addr;

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage sink: hit bitmap, lane decode, distinct-hit count.
// Define COVER_CLEAR_ON_READ_EN to zero each word as it is read out.
module cover_toggle_collector
  import cover_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ev_valid,
  input  logic [IDX_W-1:0] i_ev_index,
  input  logic [LANES-1:0] i_ev_mask,
  input  logic             i_clr_req,
  input  logic             i_dump_req,
  output logic             o_dump_busy,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output cover_word_t      o_rd_data,
  output logic [AW-1:0]    o_rd_addr,
  output logic             o_rd_last,
  output logic [CNT_W-1:0] o_hit_count,
  output logic             o_ev_oob
);

  cover_word_t      r_map [NUM_WORDS];
  logic [CNT_W-1:0] r_hit;
  logic             r_oob;

  logic [CNT_W-1:0] w_lane_idx [LANES];
  logic [LANES-1:0] w_lane_set;
  logic [LANES-1:0] w_lane_oob;
  logic [LANES-1:0] w_lane_new;
  logic [CNT_W-1:0] w_new_cnt;
  logic [CNT_W-1:0] w_hit_sum;
  logic [CNT_W-1:0] w_hit_nx;
  logic [AW-1:0]    w_sel;
  cover_word_t      w_sel_word;
  logic             w_clear;

  // per-lane absolute index, range check and "was still 0" test
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_idx[i] = CNT_W'(i_ev_index) + CNT_W'(i);
      w_lane_set[i] = i_ev_valid && i_ev_mask[i] &&
                      (w_lane_idx[i] < CNT_W'(COVER_TOTAL));
      w_lane_oob[i] = i_ev_valid && i_ev_mask[i] &&
                      !(w_lane_idx[i] < CNT_W'(COVER_TOTAL));
      w_lane_new[i] = w_lane_set[i] &&
        !r_map[w_lane_idx[i][IDX_W-1:BIT_W]][w_lane_idx[i][BIT_W-1:0]];
    end
  end

  // popcount of fresh hits and saturating count update
  always_comb begin
    w_new_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      w_new_cnt = w_new_cnt + CNT_W'(w_lane_new[i]);
    end
    w_hit_sum = r_hit + w_new_cnt;
    w_hit_nx  = (w_hit_sum > CNT_W'(COVER_TOTAL)) ?
                CNT_W'(COVER_TOTAL) : w_hit_sum;
  end

  assign w_sel_word = (w_sel < AW'(NUM_WORDS)) ? r_map[w_sel] : '0;

  // bitmap: clear, optional read-clear, then lane sets (a set beats a read-clear)
  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        r_map[w] <= '0;
      end
    end else begin
`ifdef COVER_CLEAR_ON_READ_EN
      if (o_rd_valid && i_rd_ready) begin
        r_map[o_rd_addr] <= '0;
      end
`endif
      for (int i = 0; i < LANES; i++) begin
        if (w_lane_set[i]) begin
          r_map[w_lane_idx[i][IDX_W-1:BIT_W]][w_lane_idx[i][BIT_W-1:0]] <= 1'b1;
        end
      end
    end
  end

  // distinct-hit counter and sticky out-of-range flag
  always_ff @(posedge i_clock) begin
    if (i_reset || w_clear) begin
      r_hit <= '0;
      r_oob <= 1'b0;
    end else begin
      r_hit <= w_hit_nx;
      r_oob <= r_oob | (|w_lane_oob);
    end
  end

  cover_dump_streamer u_stream (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_clr_req   (i_clr_req),
    .i_dump_req  (i_dump_req),
    .i_rd_ready  (i_rd_ready),
    .i_word      (w_sel_word),
    .o_sel       (w_sel),
    .o_clear     (w_clear),
    .o_dump_busy (o_dump_busy),
    .o_rd_valid  (o_rd_valid),
    .o_rd_last   (o_rd_last),
    .o_rd_data   (o_rd_data),
    .o_rd_addr   (o_rd_addr)
  );

  assign o_hit_count = r_hit;
  assign o_ev_oob    = r_oob;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: bitmap model plus a queue of
// expected readout words, snapshotted when each dump is requested.
module tb_cover_toggle_collector;
  import cover_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             ev_valid;
  logic [IDX_W-1:0] ev_index;
  logic [LANES-1:0] ev_mask;
  logic             clr_req;
  logic             dump_req;
  logic             rd_ready;
  logic             dump_busy;
  logic             rd_valid;
  cover_word_t      rd_data;
  logic [AW-1:0]    rd_addr;
  logic             rd_last;
  logic [CNT_W-1:0] hit_count;
  logic             ev_oob;

  int n_chk = 0;
  int n_err = 0;

  bit          mdl [NUM_WORDS*WORD_W];
  int          mdl_hit;
  bit          mdl_oob;
  cover_word_t sb_q [$];
  cover_word_t cap [NUM_WORDS];

  always #5 clk = ~clk;

  cover_toggle_collector dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_ev_valid  (ev_valid),
    .i_ev_index  (ev_index),
    .i_ev_mask   (ev_mask),
    .i_clr_req   (clr_req),
    .i_dump_req  (dump_req),
    .o_dump_busy (dump_busy),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_rd_data   (rd_data),
    .o_rd_addr   (rd_addr),
    .o_rd_last   (rd_last),
    .o_hit_count (hit_count),
    .o_ev_oob    (ev_oob)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < NUM_WORDS*WORD_W; i++) mdl[i] = 1'b0;
    mdl_hit = 0;
    mdl_oob = 1'b0;
  endfunction

  function automatic void mdl_event(input int idx, input logic [LANES-1:0] m);
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) begin
        if (idx + i < COVER_TOTAL) begin
          if (!mdl[idx+i]) begin
            mdl[idx+i] = 1'b1;
            mdl_hit++;
          end
        end else begin
          mdl_oob = 1'b1;
        end
      end
    end
    if (mdl_hit > COVER_TOTAL) mdl_hit = COVER_TOTAL;
  endfunction

  function automatic cover_word_t mdl_word(input int w);
    cover_word_t r;
    for (int b = 0; b < WORD_W; b++) r[b] = mdl[w*WORD_W+b];
    return r;
  endfunction

  task automatic send_ev(input int idx, input logic [LANES-1:0] m);
    ev_valid = 1'b1;
    ev_index = IDX_W'(idx);
    ev_mask  = m;
    mdl_event(idx, m);
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit"}, 64'(hit_count), 64'(mdl_hit));
    chk({tag, "_oob"}, 64'(ev_oob), 64'(mdl_oob));
  endtask

  // full drain; optional event on word ev_at, driven in its handshake cycle
  task automatic do_dump(input bit stall, input int ev_at, input int ev_idx);
    int          n;
    int          cyc;
    bit          done;
    bit          held_v;
    bit          rdy;
    cover_word_t held_d;
    logic [AW-1:0] held_a;
    cover_word_t exp_w;
    bit          pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = 0; cyc = 0; done = 1'b0; held_v = 1'b0;
    held_d = '0; held_a = '0;
    sb_q.delete();
    for (int w = 0; w < NUM_WORDS; w++) sb_q.push_back(mdl_word(w));
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    while (!done && cyc < 4*NUM_WORDS+20) begin
      rdy = stall ? pat[cyc%4] : 1'b1;
      rd_ready = rdy;
      if (!rd_valid) begin
        chk("rd_valid_in_dump", 64'(rd_valid), 64'(1));
        done = 1'b1;
      end else begin
        if (held_v) begin
          chk("stall_data", 64'(rd_data), 64'(held_d));
          chk("stall_addr", 64'(rd_addr), 64'(held_a));
        end
        if (rdy) begin
          exp_w = sb_q.pop_front();
          chk("word", 64'(rd_data), 64'(exp_w));
          chk("addr", 64'(rd_addr), 64'(n));
          chk("last", 64'(rd_last), 64'(n == NUM_WORDS-1));
          cap[n] = rd_data;
          if (n == ev_at) begin
            ev_valid = 1'b1;
            ev_index = IDX_W'(ev_idx);
            ev_mask  = LANES'(1);
            mdl_event(ev_idx, LANES'(1));
          end
`ifdef COVER_CLEAR_ON_READ_EN
          for (int b = 0; b < WORD_W; b++) begin
            if (!(n == ev_at && n*WORD_W+b == ev_idx)) mdl[n*WORD_W+b] = 1'b0;
          end
`endif
          if (n == NUM_WORDS-1) done = 1'b1;
          n++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_d = rd_data;
          held_a = rd_addr;
        end
      end
      @(negedge clk);
      ev_valid = 1'b0;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("dump_words", 64'(n), 64'(NUM_WORDS));
    chk("busy_after", 64'(dump_busy), 64'(0));
    chk("valid_after", 64'(rd_valid), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_index = '0; ev_mask = '0;
    clr_req = 1'b0; dump_req = 1'b0; rd_ready = 1'b0;
    mdl_clear();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(dump_busy), 64'(0));
    chk("rst_valid", 64'(rd_valid), 64'(0));
    chk("rst_addr", 64'(rd_addr), 64'(0));
    chk("rst_last", 64'(rd_last), 64'(0));
    chk("rst_data", 64'(rd_data), 64'(0));
    chk_cnt("rst");
    rst = 1'b0;
    @(negedge clk);

    send_ev(30, 7'b1111111);
    chk_cnt("ev1");
    send_ev(30, 7'b1111111);
    chk_cnt("ev1_rep");
    send_ev(36, 7'b0000011);
    chk_cnt("ev2");
    chk("ev2_hit8", 64'(hit_count), 64'(8));
    send_ev(10903, 7'b0011111);
    chk_cnt("ev3");
    chk("ev3_oob", 64'(ev_oob), 64'(1));

    do_dump(1'b1, -1, 0);
    chk("w0", 64'(cap[0]), 64'(32'hC000_0000));
    chk("w1", 64'(cap[1]), 64'(32'h0000_003F));
    chk("w340", 64'(cap[NUM_WORDS-1]), 64'(32'h0380_0000));

    do_dump(1'b0, 5, 5*WORD_W+7);
    chk("w5b7_now", 64'(cap[5][7]), 64'(0));
    chk_cnt("mid_ev");
    do_dump(1'b0, -1, 0);
    chk("w5b7_next", 64'(cap[5][7]), 64'(1));

    for (int idx = 0; idx < COVER_TOTAL; idx += LANES) begin
      send_ev(idx, 7'b1111111);
    end
    chk_cnt("fill");
    do_dump(1'b1, -1, 0);

    clr_req = 1'b1; dump_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0; dump_req = 1'b0;
    chk("clr_busy", 64'(dump_busy), 64'(1));
    chk("clr_valid", 64'(rd_valid), 64'(0));
    ev_valid = 1'b1; ev_index = IDX_W'(200); ev_mask = LANES'(1);
    @(negedge clk);
    ev_valid = 1'b0;
    mdl_clear();
    chk("clr_done_busy", 64'(dump_busy), 64'(0));
    chk("clr_done_valid", 64'(rd_valid), 64'(0));
    chk_cnt("clr");
    do_dump(1'b0, -1, 0);

    send_ev(100, LANES'(1));
    chk_cnt("pre_rst");
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_addr", 64'(rd_addr), 64'(3));
    rst = 1'b1;
    @(negedge clk);
    mdl_clear();
    chk("mrst_valid", 64'(rd_valid), 64'(0));
    chk("mrst_busy", 64'(dump_busy), 64'(0));
    chk("mrst_addr", 64'(rd_addr), 64'(0));
    chk("mrst_data", 64'(rd_data), 64'(0));
    chk_cnt("mrst");
    rst = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
